// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb_pkg
// Description : Shared definitions for the instruction dispatcher: instruction
//               field positions, override/lane-select extraction, the
//               untracked zero register and a constant clog2 helper.
// Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

  localparam int INSTR_W      = 32;

  // Instruction field map
  localparam int OVERRIDE_BIT = 28;  // 1 = force routing to lane_sel
  localparam int LSEL_LSB_BIT = 27;  // lane_sel = {[26],[27]}: bit 27 is the LSB
  localparam int LSEL_MSB_BIT = 26;
  localparam int SRC1_LO      = 16;  // src1 = [20:16]
  localparam int SRC2_LO      = 11;  // src2 = [15:11]
  localparam int DST_LO       = 0;   // dst  = [4:0]
  localparam int REG_W        = 5;

  // r0 is hard-wired zero: never a hazard source, never marked pending
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  // Takes instr[27:26] and reorders it into the lane_sel value {[26],[27]}.
  function automatic logic [1:0] f_lane_sel(input logic [1:0] sel_bits);
    return {sel_bits[0], sel_bits[1]};
  endfunction

  // Ceiling log2 for elaboration-time sizing (clog2(1) = 0).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/arb_lane_fifo.sv
`default_nettype none
// ============================================================================
// Module      : arb_lane_fifo
// Description : DEPTH x IW synchronous FIFO for one dispatch lane. Pointers
//               carry an extra wrap bit so full/empty are exact without a
//               separate counter. Head data reads as zero while empty.
// Revision    : 1.0 - initial release
// Ports       : clk, rst      - clock, synchronous active-high reset
//               i_push/i_data - write request and data (ignored when full)
//               i_pop         - read request (ignored when empty)
//               o_data        - head entry
//               o_full/o_empty/o_count - status
// ============================================================================
module arb_lane_fifo
  import arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IW    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [IW-1:0]          i_data,
  input  logic                   i_pop,
  output logic [IW-1:0]          o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [clog2(DEPTH):0]  o_count
);

  localparam int AW = clog2(DEPTH);

  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [IW-1:0] r_mem [DEPTH];
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Stale storage is masked so an empty lane always presents zero.
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !rst) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/dispatch_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dispatch_arbiter
// Description : Routes one instruction per cycle into one of LANES lane FIFOs.
//               Priority: forced lane (override bit), else the single lane
//               holding a pending register dependency, else the least-occupied
//               lane (lowest index on ties). Dependencies in two or more lanes
//               stall the input.
// Revision    : 1.0 - initial release
// Config      : DISPATCH_STATS_EN - adds stall_cnt, a saturating count of
//               cycles with in_valid && !in_ready.
// Ports       : clk, rst              - clock, synchronous active-high reset
//               in_valid/in_ready     - upstream handshake
//               in_instr [IW]         - instruction
//               out_valid [LANES]     - lane non-empty
//               out_ready [LANES]     - lane consumer pops head
//               out_instr [LANES*IW]  - lane i head at [i*IW +: IW]
//               stall_cnt [16]        - stall statistics (stats build only)
// ============================================================================
module dispatch_arbiter
  import arb_pkg::*;
#(
  parameter int LANES = 2,
  parameter int DEPTH = 4,
  parameter int IW    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IW-1:0]         in_instr,
  output logic [LANES-1:0]      out_valid,
  input  logic [LANES-1:0]      out_ready,
  output logic [LANES*IW-1:0]   out_instr
`ifdef DISPATCH_STATS_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  localparam int LW = clog2(LANES);
  localparam int CW = clog2(DEPTH) + 1;

  // Lane FIFO interface
  logic [LANES-1:0] w_push;
  logic [LANES-1:0] w_pop;
  logic [LANES-1:0] w_full;
  logic [LANES-1:0] w_empty;
  logic [CW-1:0]    w_count [LANES];
  logic [IW-1:0]    w_head  [LANES];

  // Scoreboard: r_cnt[l][r] = entries in lane l whose dst is r (r0 stays 0)
  logic [CW-1:0]    r_cnt [LANES][32];

  // Decoded instruction fields
  logic             w_override;
  logic [1:0]       w_lsel;
  logic [REG_W-1:0] w_src1;
  logic [REG_W-1:0] w_src2;
  logic [REG_W-1:0] w_dst;

  // Lane selection
  logic [LANES-1:0] w_hit;
  logic [LW:0]      w_nhit;
  logic [LW-1:0]    w_hit_idx;
  logic [LW-1:0]    w_min_idx;
  logic [CW-1:0]    w_min_cnt;
  logic [LW-1:0]    w_tgt;
  logic             w_tgt_ok;
  logic             w_accept;
  logic             w_unused_bits;

  assign w_override = in_instr[OVERRIDE_BIT];
  assign w_lsel     = f_lane_sel(in_instr[LSEL_LSB_BIT:LSEL_MSB_BIT]);
  assign w_src1     = in_instr[SRC1_LO +: REG_W];
  assign w_src2     = in_instr[SRC2_LO +: REG_W];
  assign w_dst      = in_instr[DST_LO +: REG_W];

  // Opcode/immediate bits and unused lane_sel bits do not affect routing.
  assign w_unused_bits = ^{in_instr, w_lsel};

  // Hazard lookup uses pre-pop counts, so a lane draining its last matching
  // entry this cycle still counts as a hit (conservative, one cycle later free).
  always_comb begin
    w_hit = '0;
    for (int l = 0; l < LANES; l++) begin
      w_hit[l] = ((w_src1 != REG_ZERO) && (r_cnt[l][w_src1] != '0)) ||
                 ((w_src2 != REG_ZERO) && (r_cnt[l][w_src2] != '0)) ||
                 ((w_dst  != REG_ZERO) && (r_cnt[l][w_dst]  != '0));
    end
  end

  always_comb begin
    w_nhit    = '0;
    w_hit_idx = '0;
    w_min_idx = '0;
    w_min_cnt = w_count[0];
    w_tgt     = '0;
    w_tgt_ok  = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      if (w_hit[l]) begin
        w_nhit    = w_nhit + 1'b1;
        w_hit_idx = l[LW-1:0];
      end
    end
    // Strict less-than keeps the lowest index on occupancy ties.
    for (int l = 1; l < LANES; l++) begin
      if (w_count[l] < w_min_cnt) begin
        w_min_cnt = w_count[l];
        w_min_idx = l[LW-1:0];
      end
    end
    if (w_override) begin
      w_tgt    = w_lsel[LW-1:0];
      w_tgt_ok = 1'b1;
    end else if (w_nhit == 1) begin
      w_tgt    = w_hit_idx;
      w_tgt_ok = 1'b1;
    end else if (w_nhit == 0) begin
      w_tgt    = w_min_idx;
      w_tgt_ok = 1'b1;
    end
  end

  // Full is judged before any same-cycle pop, keeping in_ready off the
  // out_ready path.
  assign in_ready = w_tgt_ok && !w_full[w_tgt];
  assign w_accept = in_valid && in_ready;
  assign w_pop    = out_ready & ~w_empty;

  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign w_push[l] = w_accept && (w_tgt == l[LW-1:0]);

      arb_lane_fifo #(
        .DEPTH (DEPTH),
        .IW    (IW)
      ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push[l]),
        .i_data  (in_instr),
        .i_pop   (w_pop[l]),
        .o_data  (w_head[l]),
        .o_full  (w_full[l]),
        .o_empty (w_empty[l]),
        .o_count (w_count[l])
      );

      assign out_valid[l]            = ~w_empty[l];
      assign out_instr[l*IW +: IW]   = w_head[l];
    end
  endgenerate

  // Push and pop of the same register in the same lane cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int l = 0; l < LANES; l++) begin
        for (int r = 0; r < 32; r++) begin
          r_cnt[l][r] <= '0;
        end
      end
    end else begin
      for (int l = 0; l < LANES; l++) begin
        for (int r = 1; r < 32; r++) begin
          if ((w_push[l] && (w_dst == r[REG_W-1:0])) &&
              !(w_pop[l] && (w_head[l][DST_LO +: REG_W] == r[REG_W-1:0]))) begin
            r_cnt[l][r] <= r_cnt[l][r] + 1'b1;
          end else if (!(w_push[l] && (w_dst == r[REG_W-1:0])) &&
                       (w_pop[l] && (w_head[l][DST_LO +: REG_W] == r[REG_W-1:0]))) begin
            r_cnt[l][r] <= r_cnt[l][r] - 1'b1;
          end
        end
      end
    end
  end

`ifdef DISPATCH_STATS_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (in_valid && !in_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dispatch_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dispatch_arbiter
// Description : Directed self-checking bench for dispatch_arbiter with
//               LANES=2, DEPTH=4: override routing, dependency affinity,
//               dual-hit stall, full-lane stall, r0 handling, mid-flight reset
//               and (stats build) stall counting.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dispatch_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [1:0]  out_valid;
  logic [1:0]  out_ready;
  logic [63:0] out_instr;
`ifdef DISPATCH_STATS_EN
  logic [15:0] stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dispatch_arbiter #(
    .LANES (2),
    .DEPTH (4),
    .IW    (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr)
`ifdef DISPATCH_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 2'b00;
    tick();
    rst = 1'b0;
  endtask

  // Present one instruction, require it to be accepted, and clock it in.
  task automatic push(input string tag, input logic [31:0] instr);
    in_valid = 1'b1;
    in_instr = instr;
    #1;
    chk(tag, {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_instr  = 32'h0;
    out_ready = 2'b00;
    tick();
    tick();
    rst = 1'b0;
    #1;

    // ---------------- reset state ----------------
    chk("rst_out_valid", {62'd0, out_valid}, 64'd0);
    chk("rst_out_instr", out_instr, 64'd0);
    chk("rst_in_ready",  {63'd0, in_ready}, 64'd1);

    // ---------------- override ----------------
    push("ovr_rdy0", 32'h1000_0001);
    chk("ovr_valid0", {62'd0, out_valid}, 64'd1);
    chk("ovr_instr0", out_instr, 64'h0000_0000_1000_0001);
    push("ovr_rdy1", 32'h1800_0007);
    chk("ovr_valid1", {62'd0, out_valid}, 64'd3);
    chk("ovr_instr1", out_instr, 64'h1800_0007_1000_0001);

    // ---------------- affinity ----------------
    do_reset();
    push("aff_a", 32'h0010_8815);                 // dst r21 -> lane0 (tie)
    push("aff_b", 32'h0015_0006);                 // src1 r21 -> lane0
    chk("aff_b_valid", {62'd0, out_valid}, 64'd1);
    chk("aff_b_head",  out_instr, 64'h0000_0000_0010_8815);
    push("aff_c", 32'h0003_2005);                 // independent -> lane1
    chk("aff_c_valid", {62'd0, out_valid}, 64'd3);
    chk("aff_c_heads", out_instr, 64'h0003_2005_0010_8815);
    out_ready = 2'b01;
    tick();
    out_ready = 2'b00;
    chk("aff_pop0_head", out_instr, 64'h0003_2005_0015_0006);
    // occupancy 1/1 would pick lane0; src1=r5 dependency must pick lane1
    push("aff_d", 32'h0005_0000);
    out_ready = 2'b10;
    tick();
    out_ready = 2'b00;
    chk("aff_d_lane1", out_instr, 64'h0005_0000_0015_0006);

    // ---------------- dual-hit stall ----------------
    do_reset();
    push("dh_r1", 32'h1000_0001);
    push("dh_r2", 32'h1800_0002);
    in_valid = 1'b1;
    in_instr = 32'h0001_1009;                     // src1 r1, src2 r2
    #1;
    chk("dh_stall", {63'd0, in_ready}, 64'd0);
    out_ready = 2'b10;
    #1;
    chk("dh_stall_prepop", {63'd0, in_ready}, 64'd0);
    tick();
    out_ready = 2'b00;
    #1;
    chk("dh_release", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    chk("dh_valid", {62'd0, out_valid}, 64'd1);
    out_ready = 2'b01;
    tick();
    out_ready = 2'b00;
    chk("dh_lane0_second", out_instr, 64'h0000_0000_0001_1009);

    // ---------------- full lane ----------------
    do_reset();
    for (int k = 1; k <= 4; k++) push("full_fill", 32'h1000_0000 | k);
    in_valid = 1'b1;
    in_instr = 32'h1000_0005;
    #1;
    chk("full_stall", {63'd0, in_ready}, 64'd0);
    out_ready = 2'b01;
    #1;
    chk("full_poppush_stall", {63'd0, in_ready}, 64'd0);
    tick();
    out_ready = 2'b00;
    #1;
    chk("full_next_ready", {63'd0, in_ready}, 64'd1);
    chk("full_head_after_pop", out_instr, 64'h0000_0000_1000_0002);
    tick();
    in_instr = 32'h1000_0006;
    #1;
    chk("full_again", {63'd0, in_ready}, 64'd0);
    in_valid = 1'b0;

    // ---------------- r0 never a hazard ----------------
    do_reset();
    push("r0_l0", 32'h1000_0000);
    push("r0_l1", 32'h1800_0000);
    push("r0_free", 32'h0000_0000);
    chk("r0_valid", {62'd0, out_valid}, 64'd3);

    // ---------------- reset mid-flight ----------------
    push("mf_r1", 32'h1000_0001);
    push("mf_r2", 32'h1800_0002);
    in_instr = 32'h0001_1009;
    #1;
    chk("mf_pre_hazard", {63'd0, in_ready}, 64'd0);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h1000_0005;                     // in-flight accept to drop
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("mf_out_valid", {62'd0, out_valid}, 64'd0);
    chk("mf_out_instr", out_instr, 64'd0);
    in_instr = 32'h0001_1009;
    #1;
    chk("mf_hazard_cleared", {63'd0, in_ready}, 64'd1);
`ifdef DISPATCH_STATS_EN
    chk("mf_stall_cnt0", {48'd0, stall_cnt}, 64'd0);
`endif
    for (int k = 1; k <= 4; k++) push("mf_fill", 32'h1000_0000 | k);
    chk("mf_fill_head", out_instr, 64'h0000_0000_1000_0001);
    chk("mf_fill_valid", {62'd0, out_valid}, 64'd1);
    in_valid = 1'b1;
    in_instr = 32'h1000_0005;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("mf_stall", {63'd0, in_ready}, 64'd0);
      tick();
    end
    in_valid = 1'b0;
`ifdef DISPATCH_STATS_EN
    chk("mf_stall_cnt3", {48'd0, stall_cnt}, 64'd3);
`endif
    tick();
`ifdef DISPATCH_STATS_EN
    chk("mf_stall_cnt_hold", {48'd0, stall_cnt}, 64'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
